// File: rtl/ps2_rx_decoder.sv
// -----------------------------------------------------------------------------
// ps2_rx_decoder
// Receives PS/2 keyboard frames (start, 8 data LSB first, odd parity, stop)
// from raw pad signals and turns the scan-code byte stream into key events.
// E0 marks an extended key, F0 marks a release, and acknowledge/self-test
// bytes (FA, AA, EE, FE) are dropped.
//
// Parameters:
//   TIMEOUT_CYCLES : idle cycles after which a partial frame is aborted
//   FILTER_LEN     : consecutive equal samples before the filtered clock moves
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   ps2_clk_in  in   raw PS/2 clock (asynchronous)
//   ps2_dat_in  in   raw PS/2 data  (asynchronous)
//   key_code    out  last decoded scan code, held until the next key event
//   key_ext     out  last code was preceded by E0
//   make_pulse  out  one-cycle strobe on a key press
//   break_pulse out  one-cycle strobe on a key release
//   err_pulse   out  one-cycle strobe on parity, stop-bit or timeout error
//
// Optional feature macro: PS2_TYPEMATIC_FILTER_EN
//   When defined, repeated makes of the same {ext, code} with no release in
//   between (keyboard auto-repeat) are swallowed.
// -----------------------------------------------------------------------------
module ps2_rx_decoder #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       make_pulse,
    output logic       break_pulse,
    output logic       err_pulse
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Odd parity holds when data plus parity bit contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    logic          clk_meta_r, clk_sync_r;
    logic          dat_meta_r, dat_sync_r;
    logic          filt_clk_r;
    logic [FW-1:0] filt_cnt_r;
    logic          bit_edge_s;
    state_t        state_r;
    logic [2:0]    bit_cnt_r;
    logic [7:0]    shift_r;
    logic          par_ok_r;
    logic [TW-1:0] to_cnt_r;
    logic          ext_r;
    logic          brk_r;
`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [8:0]    last_r;
    logic          last_vld_r;
    logic          rpt_match_s;

    assign rpt_match_s = last_vld_r && (last_r == {ext_r, shift_r});
`endif

    // Two-flop synchronizers; idle PS/2 lines are high, so reset to 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta_r <= 1'b1;
            clk_sync_r <= 1'b1;
            dat_meta_r <= 1'b1;
            dat_sync_r <= 1'b1;
        end else begin
            clk_meta_r <= ps2_clk_in;
            clk_sync_r <= clk_meta_r;
            dat_meta_r <= ps2_dat_in;
            dat_sync_r <= dat_meta_r;
        end
    end

    // Glitch filter: the filtered clock follows only after FILTER_LEN
    // consecutive samples disagree with it; any agreeing sample restarts the run.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_clk_r <= 1'b1;
            filt_cnt_r <= '0;
        end else if (clk_sync_r == filt_clk_r) begin
            filt_cnt_r <= '0;
        end else if (filt_cnt_r == FILT_LAST) begin
            filt_clk_r <= clk_sync_r;
            filt_cnt_r <= '0;
        end else begin
            filt_cnt_r <= filt_cnt_r + {{(FW-1){1'b0}}, 1'b1};
        end
    end

    // Bit edge is the single cycle in which the filtered clock falls; the
    // data synchronizer has the same latency, so dat_sync_r is aligned with it.
    assign bit_edge_s = filt_clk_r & ~clk_sync_r & (filt_cnt_r == FILT_LAST);

    // Frame FSM, timeout supervision, prefix tracking and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'h00;
            par_ok_r    <= 1'b0;
            to_cnt_r    <= '0;
            ext_r       <= 1'b0;
            brk_r       <= 1'b0;
            key_code    <= 8'h00;
            key_ext     <= 1'b0;
            make_pulse  <= 1'b0;
            break_pulse <= 1'b0;
            err_pulse   <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
            last_r      <= 9'h000;
            last_vld_r  <= 1'b0;
`endif
        end else begin
            make_pulse  <= 1'b0;
            break_pulse <= 1'b0;
            err_pulse   <= 1'b0;
            if (bit_edge_s) begin
                // A bit edge always wins over a coincident timeout.
                to_cnt_r <= '0;
                case (state_r)
                    IDLE: begin
                        if (!dat_sync_r) begin
                            state_r   <= DATA;
                            bit_cnt_r <= 3'd0;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    DATA: begin
                        shift_r   <= {dat_sync_r, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= PARITY;
                        end else begin
                            state_r <= DATA;
                        end
                    end
                    PARITY: begin
                        par_ok_r <= odd_parity_ok(shift_r, dat_sync_r);
                        state_r  <= STOP;
                    end
                    STOP: begin
                        state_r <= IDLE;
                        if (dat_sync_r && par_ok_r) begin
                            case (shift_r)
                                8'hE0: ext_r <= 1'b1;
                                8'hF0: brk_r <= 1'b1;
                                8'hFA, 8'hAA, 8'hEE, 8'hFE: begin
                                end
                                default: begin
                                    ext_r <= 1'b0;
                                    brk_r <= 1'b0;
                                    if (brk_r) begin
                                        key_code    <= shift_r;
                                        key_ext     <= ext_r;
                                        break_pulse <= 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
                                        if (rpt_match_s) begin
                                            last_vld_r <= 1'b0;
                                        end else begin
                                            last_vld_r <= last_vld_r;
                                        end
`endif
                                    end else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
                                        // Auto-repeat of the held key: swallow it.
                                        if (!rpt_match_s) begin
                                            key_code   <= shift_r;
                                            key_ext    <= ext_r;
                                            make_pulse <= 1'b1;
                                            last_r     <= {ext_r, shift_r};
                                            last_vld_r <= 1'b1;
                                        end else begin
                                            last_vld_r <= 1'b1;
                                        end
`else
                                        key_code   <= shift_r;
                                        key_ext    <= ext_r;
                                        make_pulse <= 1'b1;
`endif
                                    end
                                end
                            endcase
                        end else begin
                            err_pulse <= 1'b1;
                            ext_r     <= 1'b0;
                            brk_r     <= 1'b0;
                        end
                    end
                    default: state_r <= IDLE;
                endcase
            end else if (state_r != IDLE) begin
                if (to_cnt_r == TO_LAST) begin
                    to_cnt_r  <= '0;
                    state_r   <= IDLE;
                    err_pulse <= 1'b1;
                end else begin
                    to_cnt_r <= to_cnt_r + {{(TW-1){1'b0}}, 1'b1};
                end
            end else begin
                to_cnt_r <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx_decoder.sv
module tb_ps2_rx_decoder;

    localparam int TO = 2000;
    localparam int FL = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic [7:0] key_code;
    logic       key_ext;
    logic       make_pulse;
    logic       break_pulse;
    logic       err_pulse;

    always #10 clk = ~clk;

    ps2_rx_decoder #(.TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .make_pulse (make_pulse),
        .break_pulse(break_pulse),
        .err_pulse  (err_pulse)
    );

    int tests = 0;
    int fails = 0;
    // observed and expected event counts
    int n_make = 0, n_break = 0, n_err = 0;
    int e_make = 0, e_break = 0, e_err = 0;
    bit prev_pulse = 1'b0;

    // reference model state: what the keyboard protocol says should be latched
    bit         m_ext, m_brk, m_last_vld;
    logic [8:0] m_last;
    logic [7:0] m_code;
    bit         m_kext;

    task automatic model_reset();
        m_ext = 1'b0; m_brk = 1'b0; m_last_vld = 1'b0; m_last = 9'h000;
        m_code = 8'h00; m_kext = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit ok);
        if (!ok) begin
            e_err++;
            m_ext = 1'b0;
            m_brk = 1'b0;
            return;
        end
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hFA || b == 8'hAA || b == 8'hEE || b == 8'hFE) m_ext = m_ext;
        else begin
            if (m_brk) begin
                e_break++;
                m_code = b;
                m_kext = m_ext;
`ifdef PS2_TYPEMATIC_FILTER_EN
                if (m_last_vld && m_last == {m_ext, b}) m_last_vld = 1'b0;
`endif
            end else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
                if (!(m_last_vld && m_last == {m_ext, b})) begin
                    e_make++;
                    m_code = b;
                    m_kext = m_ext;
                    m_last = {m_ext, b};
                    m_last_vld = 1'b1;
                end
`else
                e_make++;
                m_code = b;
                m_kext = m_ext;
`endif
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    // one clock, sampled on the falling edge; counts strobes and checks exclusivity
    task automatic tick();
        @(negedge clk);
        if (make_pulse)  n_make++;
        if (break_pulse) n_break++;
        if (err_pulse)   n_err++;
        if (make_pulse || break_pulse || err_pulse) begin
            tests++;
            assert ((int'(make_pulse) + int'(break_pulse) + int'(err_pulse)) == 1 && !prev_pulse)
            else begin
                fails++;
                $error("FAIL pulse_excl observed mbe=%b%b%b prev=%b expected one isolated strobe",
                       make_pulse, break_pulse, err_pulse, prev_pulse);
            end
        end
        prev_pulse = make_pulse || break_pulse || err_pulse;
    endtask

    task automatic drive_bit(input bit v, input int h);
        ps2_dat_in = v;
        repeat (h) tick();
        ps2_clk_in = 1'b0;
        repeat (h) tick();
        ps2_clk_in = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit stop_bit);
        int h;
        logic p;
        h = $urandom_range(15, 30);
        p = ~(^b) ^ flip_par;
        drive_bit(1'b0, h);
        for (int i = 0; i < 8; i++) drive_bit(b[i], h);
        drive_bit(p, h);
        drive_bit(stop_bit, h);
        ps2_dat_in = 1'b1;
        repeat (4 * h) tick();
    endtask

    task automatic frame(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1);
        model_byte(b, 1'b1);
    endtask

    task automatic check_state(input string tag);
        tests++;
        assert (n_make === e_make) else begin
            fails++; $error("FAIL %s make_cnt observed=%0d expected=%0d", tag, n_make, e_make);
        end
        tests++;
        assert (n_break === e_break) else begin
            fails++; $error("FAIL %s break_cnt observed=%0d expected=%0d", tag, n_break, e_break);
        end
        tests++;
        assert (n_err === e_err) else begin
            fails++; $error("FAIL %s err_cnt observed=%0d expected=%0d", tag, n_err, e_err);
        end
        tests++;
        assert (key_code === m_code) else begin
            fails++; $error("FAIL %s key_code observed=%h expected=%h", tag, key_code, m_code);
        end
        tests++;
        assert (key_ext === m_kext) else begin
            fails++; $error("FAIL %s key_ext observed=%b expected=%b", tag, key_ext, m_kext);
        end
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] pick [6];
        logic [7:0] acks [4];
        int sel;
        pick[0] = 8'h1C; pick[1] = 8'h1D; pick[2] = 8'h29;
        pick[3] = 8'h75; pick[4] = 8'h16; pick[5] = 8'h5A;
        acks[0] = 8'hFA; acks[1] = 8'hAA; acks[2] = 8'hEE; acks[3] = 8'hFE;

        // reset state
        reset = 1'b1; ps2_clk_in = 1'b1; ps2_dat_in = 1'b1;
        model_reset();
        repeat (5) tick();
        check_state("reset");
        tests++;
        assert ({make_pulse, break_pulse, err_pulse} === 3'b000) else begin
            fails++; $error("FAIL reset_pulses observed=%b expected=000", {make_pulse, break_pulse, err_pulse});
        end
        reset = 1'b0;
        repeat (5) tick();

        // single make
        frame(8'h1C);
        check_state("make_1c");

        // extended release
        frame(8'hE0); frame(8'hF0); frame(8'h75);
        check_state("ext_break_75");

        // parity error then recovery
        send_frame(8'h29, 1'b1, 1'b1);
        model_byte(8'h29, 1'b0);
        check_state("parity_err");
        frame(8'h29);
        check_state("after_parity");

        // stop-bit error
        send_frame(8'h33, 1'b0, 1'b0);
        model_byte(8'h33, 1'b0);
        check_state("stop_err");

        // partial frame aborted by timeout, then a good frame
        drive_bit(1'b0, 20);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 20);
        ps2_dat_in = 1'b1;
        repeat (TO + 100) tick();
        e_err++;
        check_state("timeout");
        frame(8'h16);
        check_state("after_timeout");

        // short clock glitches with data low must not start a frame
        ps2_dat_in = 1'b0; ps2_clk_in = 1'b0;
        repeat (5) tick();
        ps2_clk_in = 1'b1;
        repeat (20) tick();
        ps2_dat_in = 1'b1;
        repeat (TO + 100) tick();
        check_state("glitch5");
        ps2_dat_in = 1'b0; ps2_clk_in = 1'b0;
        repeat (FL - 1) tick();
        ps2_clk_in = 1'b1;
        repeat (20) tick();
        ps2_dat_in = 1'b1;
        repeat (TO + 100) tick();
        check_state("glitch7");

        // typematic sequence
        frame(8'h1D); frame(8'h1D); frame(8'h1D);
        frame(8'hF0); frame(8'h1D);
        frame(8'h1D);
        check_state("typematic");

        // reset in mid-frame discards it silently
        frame(8'hE0);
        drive_bit(1'b0, 20);
        for (int i = 0; i < 3; i++) drive_bit(1'b0, 20);
        ps2_dat_in = 1'b1;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        model_reset();
        repeat (2) tick();
        check_state("mid_reset");
        frame(8'h5A);
        check_state("after_reset");

        // randomized byte stream
        for (int n = 0; n < 30; n++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) frame(8'hE0);
            else if (sel == 1) frame(8'hF0);
            else if (sel == 2) frame(acks[$urandom_range(0, 3)]);
            else if (sel == 3) begin
                b = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 1) == 0) send_frame(b, 1'b1, 1'b1);
                else send_frame(b, 1'b0, 1'b0);
                model_byte(b, 1'b0);
            end else if (sel < 7) frame(pick[$urandom_range(0, 5)]);
            else frame(8'($urandom_range(0, 255)));
            check_state("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
